// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Hardwired control sequencer for one register-register ALU instruction on
//   the shared-bus datapath. On an accepted start it fetches the instruction
//   (PC -> MAR, memory -> MDR -> IR, PC incremented through Z), moves Rb into Y,
//   runs the ALU against Rc and writes Z back into Ra.
//
// Optional feature macro: WIDE_RESULT_EN
//   When defined, MUL_OP / DIV_OP results are written as two words: the low
//   word to LO in T5 and the high word to HI in T6. When undefined, T6, LOin,
//   HIin and Zhighout are never asserted and every op writes Z low to Ra.
//
// Ports
//   clk, clr           clock and synchronous active-high clear
//   start              begin one instruction (sampled only in IDLE)
//   op_code            ALU operation, latched on accepted start
//   ra_sel/rb_sel/rc_sel  destination / first source / second source selects
//   mem_rdy            memory data valid while in T1
//   PCout ... Read     single-bit datapath strobes
//   Rin, Rout          one-hot register load / drive enables
//   alu_ctrl           ALU operation select (holds last driven value)
//   busy               high in every state except IDLE
//   done               one-cycle pulse in the final write-back state

module alu_op_sequencer #(
    parameter int                  NUM_REGS  = 16,
    parameter int                  SEL_W     = 4,
    parameter int                  OPCODE_W  = 5,
    parameter logic [OPCODE_W-1:0] PC_INC_OP = 5'd12,
    parameter logic [OPCODE_W-1:0] MUL_OP    = 5'd14,
    parameter logic [OPCODE_W-1:0] DIV_OP    = 5'd15
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic [OPCODE_W-1:0] op_code,
    input  logic [SEL_W-1:0]    ra_sel,
    input  logic [SEL_W-1:0]    rb_sel,
    input  logic [SEL_W-1:0]    rc_sel,
    input  logic                mem_rdy,
    output logic                PCout,
    output logic                PCin,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                LOin,
    output logic                HIin,
    output logic                Read,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [OPCODE_W-1:0] alu_ctrl,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6
    } state_t;

    // Elaboration-time sanity checks on the parameter set: the selects must
    // reach every register and the special ALU codes must not collide.
    generate
        if ((2 ** SEL_W) < NUM_REGS) begin : g_sel_too_narrow
            $error("alu_op_sequencer: SEL_W too narrow for NUM_REGS");
        end
        if ((MUL_OP == PC_INC_OP) || (DIV_OP == PC_INC_OP)) begin : g_op_clash
            $error("alu_op_sequencer: MUL_OP/DIV_OP collide with PC_INC_OP");
        end
    endgenerate

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [SEL_W-1:0]    ra_q, ra_d;
    logic [SEL_W-1:0]    rb_q, rb_d;
    logic [SEL_W-1:0]    rc_q, rc_d;
    logic [OPCODE_W-1:0] alu_ctrl_q, alu_ctrl_d;
    // Set while T1 is being repeated for a memory stall, so the one-shot
    // PC update strobes fire only in the first T1 cycle.
    logic                t1_stall_q, t1_stall_d;

    // Selects outside the register file decode to an all-zero vector.
    function automatic logic [NUM_REGS-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_REGS-1:0] vec;
        vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel == SEL_W'(i)) begin
                vec[i] = 1'b1;
            end
        end
        return vec;
    endfunction

    // Next-state logic and Moore decode of the strobes from registered state.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        rc_d       = rc_q;
        t1_stall_d = 1'b0;
        alu_ctrl   = alu_ctrl_q;
        PCout      = 1'b0;
        PCin       = 1'b0;
        MARin      = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zin        = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        LOin       = 1'b0;
        HIin       = 1'b0;
        Read       = 1'b0;
        Rin        = '0;
        Rout       = '0;
        done       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = T0;
                    op_d    = op_code;
                    ra_d    = ra_sel;
                    rb_d    = rb_sel;
                    rc_d    = rc_sel;
                end
            end
            T0: begin
                PCout    = 1'b1;
                MARin    = 1'b1;
                Zin      = 1'b1;
                alu_ctrl = PC_INC_OP;
                state_d  = T1;
            end
            T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
                if (!t1_stall_q) begin
                    PCin    = 1'b1;
                    Zlowout = 1'b1;
                end
                if (mem_rdy) begin
                    state_d = T2;
                end else begin
                    t1_stall_d = 1'b1;
                end
            end
            T2: begin
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = T3;
            end
            T3: begin
                Rout    = sel_to_onehot(rb_q);
                Yin     = 1'b1;
                state_d = T4;
            end
            T4: begin
                Rout     = sel_to_onehot(rc_q);
                Zin      = 1'b1;
                alu_ctrl = op_q;
                state_d  = T5;
            end
            T5: begin
                Zlowout = 1'b1;
`ifdef WIDE_RESULT_EN
                if ((op_q == MUL_OP) || (op_q == DIV_OP)) begin
                    LOin    = 1'b1;
                    state_d = T6;
                end else begin
                    Rin     = sel_to_onehot(ra_q);
                    done    = 1'b1;
                    state_d = IDLE;
                end
`else
                Rin     = sel_to_onehot(ra_q);
                done    = 1'b1;
                state_d = IDLE;
`endif
            end
`ifdef WIDE_RESULT_EN
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
                state_d  = IDLE;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        alu_ctrl_d = alu_ctrl;
        busy       = (state_q != IDLE);
    end

    // State and latched-operand registers; clr overrides everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            op_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            rc_q       <= '0;
            alu_ctrl_q <= '0;
            t1_stall_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            ra_q       <= ra_d;
            rb_q       <= rb_d;
            rc_q       <= rc_d;
            alu_ctrl_q <= alu_ctrl_d;
            t1_stall_q <= t1_stall_d;
        end
    end

endmodule
